video_address_seq: RTL and testbench
====================================

Name: video_address_seq

Overview:
- Parametrised next-generation PPU loopy address unit.
- Holds v/t/fine-x/write-latch scroll state and generates rendering fetch addresses.
- Adds a sequenced CPU PPUDATA access engine that defers CPU accesses to idle render slots.
- Adds a one-deep read buffer with palette bypass, and nametable mirroring decode for CIRAM.
- Sits between the register decoder, the render timing controller and the PPU bus arbiter.

Parameters:
- ADDR_W, 14: PPU bus address width. Must be >= 14; bits above 13 are driven 0.
- PAL_BYPASS, 1: when 1, PPUDATA reads of $3F00-$3FFF return I_pal_data directly.
- FINE_W, 3: fine-X width. 3 gives 8-pixel tiles; values > 3 zero-extend the scroll input.

Ports:
- I_clock in 1: clock.
- I_reset in 1: asynchronous, active-low reset.
- I_wren in 8: one-hot register write strobes. idx 0 CTRL, 2 STAT, 5 SCRL, 6 ADDR, 7 DATA.
- I_rden in 8: one-hot register read strobes, same indices.
- I_data in 8: CPU write data.
- O_data out 8: CPU read data for PPUDATA.
- I_ppuctrl in 8: bit2 selects increment 32/1; bit4 selects background pattern table.
- I_ppumask in 8: bit3|bit4 = rendering enabled.
- I_vblank in 1: vertical blank active.
- I_idle_slot in 1: render bus free this cycle. No render strobes are asserted while it is high.
- I_fetch_nt, I_fetch_at, I_fetch_lo, I_fetch_hi in 1 each: render fetch-address strobes.
- I_nt_latch in 1: capture the tile index from I_vid_data.
- I_incr_h, I_incr_v, I_copy_h, I_copy_v in 1 each: loopy update strobes.
- I_mirror in 3: 0 horizontal, 1 vertical, 2 single-A, 3 single-B, 4 four-screen.
- I_vid_data in 8: PPU bus read data. Valid one cycle after the address is driven.
- I_pal_data in 8: palette RAM read data for the current v.
- O_vid_addr out ADDR_W: PPU bus address, registered.
- O_vid_wren out 1: PPU bus write strobe.
- O_vid_data out 8: PPU bus write data.
- O_vid_fine out FINE_W: fine-X scroll.
- O_ciram_a10 out 1: mapped nametable select.
- O_busy out 1: CPU access in flight.
- O_overrun out 1: one-cycle pulse when a DATA access is dropped.

Behaviour:
- Reset (async, active-low):
  - v, t, fine, w, rd_buf, tile index and wr_hold cleared.
  - FSM to IDLE. All outputs 0.
  - Reset mid-access abandons the access; no write and no increment occur.
- Register writes and reads:
  - CTRL write: t[11:10] <= d[1:0].
  - STAT read: w <= 0. This has priority over any flip.
  - SCRL/ADDR write: w toggles.
  - SCRL, w=0: t[4:0] <= d[7:3]; fine <= d[2:0].
  - SCRL, w=1: t[9:5] <= d[7:3]; t[14:12] <= d[2:0].
  - ADDR, w=0: t[13:8] <= d[5:0]; t[14] <= 0.
  - ADDR, w=1: t[7:0] <= d; v <= {t[14:8], d}.
  - These are accepted in any FSM state. A pending access uses v as of ISSUE.
- Access FSM: IDLE -> WAIT -> ISSUE -> (CAPT) -> INCR -> IDLE.
  - IDLE: a DATA rd/wr latches the op, write data and increment (32 if ppuctrl[2], else 1). O_busy goes high.
  - Access start: if rendering is off or I_vblank=1, the next state is ISSUE; otherwise WAIT.
  - WAIT: move to ISSUE on I_idle_slot.
  - ISSUE: O_vid_addr <= v[13:0].
    - Write: O_vid_wren=1 for exactly one cycle, O_vid_data = held data, then INCR.
    - Read: go to CAPT.
  - CAPT: rd_buf <= I_vid_data, then INCR.
  - INCR: v <= v + inc, mod 2^15.
    - If any render update strobe is active the same cycle, the render update wins and INCR holds.
  - INCR -> IDLE. O_busy clears on entry to IDLE.
  - A DATA access while O_busy=1 is dropped; O_overrun pulses one cycle.
  - Read latency: the next read returns the buffered byte. CPU read-to-IDLE takes 4 cycles when rendering is off.
- Read data:
  - O_data = (PAL_BYPASS && v[13:8]==6'h3F) ? I_pal_data : rd_buf.
  - For palette reads the bus address is still issued as v & 14'h2FFF, so the buffer fills from the underlying nametable.
- Render path (only when rendering is enabled; strobes are one-hot, priority incr_h > incr_v > copy_h > copy_v):
  - NT address: {2'b10, v[11:0]}.
  - AT address: {2'b10, v[11:10], 4'hF, v[9:7], v[4:2]}.
  - LO address: {0, ppuctrl[4], tile, 0, v[14:12]}.
  - HI address: LO + 8.
  - incr_h: coarse-X +1; on wrap from 31, toggle v[10].
  - incr_v: fine-Y +1. On fine-Y overflow, coarse-Y +1. Coarse-Y 29 -> 0 toggles v[11]. Coarse-Y 31 -> 0 without toggle.
  - copy_h: v[10], v[4:0] <= t.
  - copy_v: v[11], v[9:5], v[14:12] <= t.
- Mirroring: O_ciram_a10 is combinational from O_vid_addr[11:10].
  - Horizontal: A11. Vertical: A10. Single-A: 0. Single-B: 1. Four-screen: A10.
  - Modes 5-7 behave as mode 0.

Test Plan:
- Rendering off. Write $2006 = $21 then $08; write $2007 = $5A -> one-cycle O_vid_wren at O_vid_addr=$2108, data $5A; v=$2109; O_busy high 3 cycles.
- ppuctrl[2]=1, v=$2000. Two $2007 reads with I_vid_data $11 then $22 -> first O_data is the prior buffer, second is $11; v=$2040.
- Rendering on, I_vblank=0, DATA write, I_idle_slot low for 10 cycles -> no bus write until the slot; O_busy stays high; second DATA write during wait -> O_overrun pulse, dropped.
- v=$3F05, I_pal_data=$2C, I_vid_data=$77 -> O_data=$2C immediately; bus address issued $2F05; rd_buf=$77 after access.
- Coarse-Y=29, fine-Y=7, incr_v -> coarse-Y 0, v[11] toggled. Coarse-Y=31 -> 0, no toggle. Coarse-X=31, incr_h -> v[10] toggled.
- I_mirror=1, address $2400 -> O_ciram_a10=1. I_mirror=0, address $2400 -> 0. Reset asserted in WAIT -> FSM IDLE, v=0, no write issued.

Source files
------------

// File: rtl/video_address_seq.sv
// ----------------------------------------------------------------------------
// video_address_seq
// PPU "loopy" address unit. Holds the v/t/fine-x/write-latch scroll state,
// produces render fetch addresses, and runs a small sequencer that slots CPU
// PPUDATA accesses into idle render bus cycles. Also provides the one-deep
// PPUDATA read buffer with palette bypass and the CIRAM A10 mirroring decode.
// ----------------------------------------------------------------------------
module video_address_seq #(
    parameter int ADDR_W     = 14,
    parameter int PAL_BYPASS = 1,
    parameter int FINE_W     = 3
) (
    input  logic              I_clock,
    input  logic              I_reset,
    input  logic [7:0]        I_wren,
    input  logic [7:0]        I_rden,
    input  logic [7:0]        I_data,
    output logic [7:0]        O_data,
    input  logic [7:0]        I_ppuctrl,
    input  logic [7:0]        I_ppumask,
    input  logic              I_vblank,
    input  logic              I_idle_slot,
    input  logic              I_fetch_nt,
    input  logic              I_fetch_at,
    input  logic              I_fetch_lo,
    input  logic              I_fetch_hi,
    input  logic              I_nt_latch,
    input  logic              I_incr_h,
    input  logic              I_incr_v,
    input  logic              I_copy_h,
    input  logic              I_copy_v,
    input  logic [2:0]        I_mirror,
    input  logic [7:0]        I_vid_data,
    input  logic [7:0]        I_pal_data,
    output logic [ADDR_W-1:0] O_vid_addr,
    output logic              O_vid_wren,
    output logic [7:0]        O_vid_data,
    output logic [FINE_W-1:0] O_vid_fine,
    output logic              O_ciram_a10,
    output logic              O_busy,
    output logic              O_overrun
);

    // Register strobe indices within I_wren / I_rden
    localparam int REG_CTRL = 0;
    localparam int REG_STAT = 2;
    localparam int REG_SCRL = 5;
    localparam int REG_ADDR = 6;
    localparam int REG_DATA = 7;

    localparam logic PAL_EN = (PAL_BYPASS != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE,
        S_CAPT,
        S_INCR
    } state_t;

    state_t      state_q, state_d;

    logic [14:0] v_q;
    logic [14:0] t_q;
    logic [FINE_W-1:0] fine_q;
    logic        w_q;
    logic [7:0]  rd_buf_q;
    logic [7:0]  tile_q;
    logic [7:0]  wr_hold_q;
    logic        op_wr_q;
    logic        inc32_q;
    logic [13:0] addr_q;
    logic        wren_q;
    logic [7:0]  vdata_q;
    logic        overrun_q;

    logic        rendering;
    logic        data_req;
    logic        accept;
    logic        render_upd;
    logic [14:0] v_render;
    logic [14:0] v_inc;
    logic [13:0] issue_addr;
    logic [13:0] lo_addr;

    assign rendering  = I_ppumask[3] | I_ppumask[4];
    assign data_req   = I_wren[REG_DATA] | I_rden[REG_DATA];
    assign accept     = (state_q == S_IDLE) && data_req;
    assign render_upd = rendering && (I_incr_h || I_incr_v || I_copy_h || I_copy_v);
    assign v_inc      = inc32_q ? 15'd32 : 15'd1;

    // Palette reads still go out on the bus, folded into the nametable
    // mirror, so the read buffer fills with the byte "underneath" the palette.
    assign issue_addr = (!op_wr_q && v_q[13:8] == 6'h3F) ? (v_q[13:0] & 14'h2FFF)
                                                         : v_q[13:0];
    assign lo_addr    = {1'b0, I_ppuctrl[4], tile_q, 1'b0, v_q[14:12]};

    // Access sequencer state register
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer next-state: defer to an idle render slot unless the bus is free
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch forms.
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (data_req) begin
                    state_d = (!rendering || I_vblank) ? S_ISSUE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (I_idle_slot || !rendering || I_vblank) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = op_wr_q ? S_INCR : S_CAPT;
            S_CAPT:  state_d = S_INCR;
            S_INCR:  state_d = render_upd ? S_INCR : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Latch the CPU access parameters when the sequencer accepts it
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            op_wr_q   <= 1'b0;
            inc32_q   <= 1'b0;
            wr_hold_q <= 8'h00;
        end else if (accept) begin
            op_wr_q <= I_wren[REG_DATA];
            inc32_q <= I_ppuctrl[2];
            if (I_wren[REG_DATA]) begin
                wr_hold_q <= I_data;
            end
        end
    end

    // A DATA access arriving while one is in flight is dropped and flagged
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= data_req && (state_q != S_IDLE);
        end
    end

    // Scroll registers: t, fine-x and the shared write toggle
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            t_q    <= '0;
            fine_q <= '0;
            w_q    <= 1'b0;
        end else begin
            if (I_wren[REG_CTRL]) begin
                t_q[11:10] <= I_data[1:0];
            end
            if (I_wren[REG_SCRL]) begin
                if (!w_q) begin
                    t_q[4:0] <= I_data[7:3];
                    fine_q   <= FINE_W'(I_data[2:0]);
                end else begin
                    t_q[9:5]   <= I_data[7:3];
                    t_q[14:12] <= I_data[2:0];
                end
            end
            if (I_wren[REG_ADDR]) begin
                if (!w_q) begin
                    t_q[13:8] <= I_data[5:0];
                    t_q[14]   <= 1'b0;
                end else begin
                    t_q[7:0] <= I_data;
                end
            end
            // A status read resets the toggle even if a flip lands the same cycle
            if (I_rden[REG_STAT]) begin
                w_q <= 1'b0;
            end else if (I_wren[REG_SCRL] || I_wren[REG_ADDR]) begin
                w_q <= ~w_q;
            end
        end
    end

    // Render-driven v update: one strobe at a time, incr_h highest
    always_comb begin
        v_render = v_q;
        if (I_incr_h) begin
            if (v_q[4:0] == 5'd31) begin
                v_render[4:0] = 5'd0;
                v_render[10]  = ~v_q[10];
            end else begin
                v_render[4:0] = v_q[4:0] + 5'd1;
            end
        end else if (I_incr_v) begin
            if (v_q[14:12] != 3'd7) begin
                v_render[14:12] = v_q[14:12] + 3'd1;
            end else begin
                v_render[14:12] = 3'd0;
                if (v_q[9:5] == 5'd29) begin
                    v_render[9:5] = 5'd0;
                    v_render[11]  = ~v_q[11];
                end else if (v_q[9:5] == 5'd31) begin
                    v_render[9:5] = 5'd0;
                end else begin
                    v_render[9:5] = v_q[9:5] + 5'd1;
                end
            end
        end else if (I_copy_h) begin
            v_render[10]  = t_q[10];
            v_render[4:0] = t_q[4:0];
        end else if (I_copy_v) begin
            v_render[11]    = t_q[11];
            v_render[9:5]   = t_q[9:5];
            v_render[14:12] = t_q[14:12];
        end
    end

    // v: CPU address load, then render updates, then the access increment
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            v_q <= '0;
        end else if (I_wren[REG_ADDR] && w_q) begin
            v_q <= {t_q[14:8], I_data};
        end else if (render_upd) begin
            v_q <= v_render;
        end else if (state_q == S_INCR) begin
            v_q <= v_q + v_inc;
        end
    end

    // PPU bus address/write: CPU issue slot first, otherwise render fetches
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            addr_q  <= '0;
            wren_q  <= 1'b0;
            vdata_q <= 8'h00;
        end else begin
            wren_q <= 1'b0;
            if (state_q == S_ISSUE) begin
                addr_q <= issue_addr;
                if (op_wr_q) begin
                    wren_q  <= 1'b1;
                    vdata_q <= wr_hold_q;
                end
            end else if (rendering) begin
                if (I_fetch_nt) begin
                    addr_q <= {2'b10, v_q[11:0]};
                end else if (I_fetch_at) begin
                    addr_q <= {2'b10, v_q[11:10], 4'hF, v_q[9:7], v_q[4:2]};
                end else if (I_fetch_lo) begin
                    addr_q <= lo_addr;
                end else if (I_fetch_hi) begin
                    addr_q <= lo_addr + 14'd8;
                end
            end
        end
    end

    // Read buffer fill and nametable tile index capture
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            rd_buf_q <= 8'h00;
            tile_q   <= 8'h00;
        end else begin
            if (state_q == S_CAPT) begin
                rd_buf_q <= I_vid_data;
            end
            if (I_nt_latch) begin
                tile_q <= I_vid_data;
            end
        end
    end

    // Nametable mirroring decode from the registered bus address
    always_comb begin
        O_ciram_a10 = addr_q[11];
        case (I_mirror)
            3'd0:    O_ciram_a10 = addr_q[11];
            3'd1:    O_ciram_a10 = addr_q[10];
            3'd2:    O_ciram_a10 = 1'b0;
            3'd3:    O_ciram_a10 = 1'b1;
            3'd4:    O_ciram_a10 = addr_q[10];
            default: O_ciram_a10 = addr_q[11];
        endcase
    end

    // Busy is visible from the cycle the CPU strobe is accepted
    assign O_busy     = (state_q != S_IDLE) || data_req;
    assign O_overrun  = overrun_q;
    assign O_vid_addr = ADDR_W'(addr_q);
    assign O_vid_wren = wren_q;
    assign O_vid_data = vdata_q;
    assign O_vid_fine = fine_q;
    assign O_data     = (PAL_EN && v_q[13:8] == 6'h3F) ? I_pal_data : rd_buf_q;

    // Register strobes and control bits this unit does not decode
    logic unused_bits;
    assign unused_bits = &{1'b0, I_wren[4:1], I_rden[6:3], I_rden[1:0],
                           I_ppuctrl[7:5], I_ppuctrl[3], I_ppuctrl[1:0],
                           I_ppumask[7:5], I_ppumask[2:0]};

endmodule

// File: tb/tb_video_address_seq.sv
// ----------------------------------------------------------------------------
// Directed self-checking bench for video_address_seq.
// Inputs are driven 1 ns after the rising edge; outputs sampled on the
// falling edge.
// ----------------------------------------------------------------------------
module tb_video_address_seq;

    logic        I_clock = 1'b0;
    logic        I_reset;
    logic [7:0]  I_wren, I_rden, I_data;
    logic [7:0]  O_data;
    logic [7:0]  I_ppuctrl, I_ppumask;
    logic        I_vblank, I_idle_slot;
    logic        I_fetch_nt, I_fetch_at, I_fetch_lo, I_fetch_hi, I_nt_latch;
    logic        I_incr_h, I_incr_v, I_copy_h, I_copy_v;
    logic [2:0]  I_mirror;
    logic [7:0]  I_vid_data, I_pal_data;
    logic [13:0] O_vid_addr;
    logic        O_vid_wren;
    logic [7:0]  O_vid_data;
    logic [2:0]  O_vid_fine;
    logic        O_ciram_a10, O_busy, O_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    video_address_seq #(.ADDR_W(14), .PAL_BYPASS(1), .FINE_W(3)) dut (
        .I_clock(I_clock), .I_reset(I_reset),
        .I_wren(I_wren), .I_rden(I_rden), .I_data(I_data), .O_data(O_data),
        .I_ppuctrl(I_ppuctrl), .I_ppumask(I_ppumask),
        .I_vblank(I_vblank), .I_idle_slot(I_idle_slot),
        .I_fetch_nt(I_fetch_nt), .I_fetch_at(I_fetch_at),
        .I_fetch_lo(I_fetch_lo), .I_fetch_hi(I_fetch_hi),
        .I_nt_latch(I_nt_latch),
        .I_incr_h(I_incr_h), .I_incr_v(I_incr_v),
        .I_copy_h(I_copy_h), .I_copy_v(I_copy_v),
        .I_mirror(I_mirror), .I_vid_data(I_vid_data), .I_pal_data(I_pal_data),
        .O_vid_addr(O_vid_addr), .O_vid_wren(O_vid_wren), .O_vid_data(O_vid_data),
        .O_vid_fine(O_vid_fine), .O_ciram_a10(O_ciram_a10),
        .O_busy(O_busy), .O_overrun(O_overrun)
    );

    always #5 I_clock = ~I_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge I_clock);
        #1;
    endtask

    task automatic reg_wr(input int idx, input logic [7:0] d);
        I_wren[idx] = 1'b1;
        I_data      = d;
        tick();
        I_wren = 8'h00;
    endtask

    task automatic reg_rd(input int idx);
        I_rden[idx] = 1'b1;
        tick();
        I_rden = 8'h00;
    endtask

    // 0 incr_h, 1 incr_v, 2 copy_h, 3 copy_v, 4 fetch_nt, 5 fetch_at,
    // 6 fetch_lo, 7 fetch_hi, 8 nt_latch
    task automatic strobe(input int which);
        case (which)
            0: I_incr_h   = 1'b1;
            1: I_incr_v   = 1'b1;
            2: I_copy_h   = 1'b1;
            3: I_copy_v   = 1'b1;
            4: I_fetch_nt = 1'b1;
            5: I_fetch_at = 1'b1;
            6: I_fetch_lo = 1'b1;
            7: I_fetch_hi = 1'b1;
            default: I_nt_latch = 1'b1;
        endcase
        tick();
        {I_incr_h, I_incr_v, I_copy_h, I_copy_v} = 4'b0;
        {I_fetch_nt, I_fetch_at, I_fetch_lo, I_fetch_hi, I_nt_latch} = 5'b0;
    endtask

    // One PPUDATA access run to completion; reports what was seen on the bus
    task automatic cpu_access(input string tag, input logic wr, input logic [7:0] d,
                              output logic [7:0] rdata, output int busy_cyc,
                              output int wren_cyc, output logic [13:0] waddr,
                              output logic [7:0] wdata);
        logic done;
        done     = 1'b0;
        busy_cyc = 0;
        wren_cyc = 0;
        waddr    = '0;
        wdata    = '0;
        rdata    = '0;
        if (wr) begin
            I_wren[7] = 1'b1;
            I_data    = d;
        end else begin
            I_rden[7] = 1'b1;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge I_clock);
            if (i == 0) rdata = O_data;
            if (O_vid_wren) begin
                wren_cyc++;
                waddr = O_vid_addr;
                wdata = O_vid_data;
            end
            if (!O_busy) begin
                done = 1'b1;
                break;
            end
            busy_cyc++;
            tick();
            I_wren = 8'h00;
            I_rden = 8'h00;
        end
        check({tag, "_done"}, done, 1'b1);
    endtask

    logic [7:0]  rd;
    int          nbusy, nwren, novr;
    logic [13:0] wa;
    logic [7:0]  wd;

    initial begin
        I_reset = 1'b0;
        I_wren = 0; I_rden = 0; I_data = 0;
        I_ppuctrl = 0; I_ppumask = 0; I_vblank = 0; I_idle_slot = 0;
        {I_fetch_nt, I_fetch_at, I_fetch_lo, I_fetch_hi, I_nt_latch} = 5'b0;
        {I_incr_h, I_incr_v, I_copy_h, I_copy_v} = 4'b0;
        I_mirror = 0; I_vid_data = 0; I_pal_data = 0;

        // Reset state
        tick(); tick();
        check("rst_addr", O_vid_addr, 14'h0);
        check("rst_wren", O_vid_wren, 1'b0);
        check("rst_busy", O_busy, 1'b0);
        check("rst_ovr",  O_overrun, 1'b0);
        check("rst_data", O_data, 8'h00);
        check("rst_fine", O_vid_fine, 3'd0);
        check("rst_v",    dut.v_q, 15'h0);
        I_reset = 1'b1;
        tick();

        // Rendering off: write $5A to $2108
        reg_wr(6, 8'h21);
        reg_wr(6, 8'h08);
        check("addr_load_v", dut.v_q, 15'h2108);
        cpu_access("wr1", 1'b1, 8'h5A, rd, nbusy, nwren, wa, wd);
        check("wr1_busy_cyc", nbusy, 3);
        check("wr1_wren_cyc", nwren, 1);
        check("wr1_addr", wa, 14'h2108);
        check("wr1_data", wd, 8'h5A);
        check("wr1_v", dut.v_q, 15'h2109);

        // Increment-32 reads: buffered data is one read behind
        I_ppuctrl = 8'h04;
        reg_wr(6, 8'h20);
        reg_wr(6, 8'h00);
        I_vid_data = 8'h11;
        cpu_access("rd1", 1'b0, 8'h00, rd, nbusy, nwren, wa, wd);
        check("rd1_data", rd, 8'h00);
        check("rd1_busy_cyc", nbusy, 4);
        check("rd1_wren_cyc", nwren, 0);
        I_vid_data = 8'h22;
        cpu_access("rd2", 1'b0, 8'h00, rd, nbusy, nwren, wa, wd);
        check("rd2_data", rd, 8'h11);
        check("rd2_v", dut.v_q, 15'h2040);
        check("rd2_buf", O_data, 8'h22);

        // Rendering on: access waits for an idle slot; second access dropped
        I_ppuctrl = 8'h00;
        I_ppumask = 8'h18;
        I_wren[7] = 1'b1;
        I_data    = 8'hA5;
        tick();
        I_wren = 8'h00;
        nbusy = 0; nwren = 0; novr = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                I_wren[7] = 1'b1;
                I_data    = 8'hFF;
            end
            @(negedge I_clock);
            if (O_busy)     nbusy++;
            if (O_vid_wren) nwren++;
            if (O_overrun)  novr++;
            tick();
            I_wren = 8'h00;
        end
        check("wait_busy_cyc", nbusy, 10);
        check("wait_no_write", nwren, 0);
        check("wait_overrun", novr, 1);
        I_idle_slot = 1'b1;
        tick();
        I_idle_slot = 1'b0;
        @(negedge I_clock);
        check("issue_wren_lo", O_vid_wren, 1'b0);
        tick();
        @(negedge I_clock);
        check("slot_wren", O_vid_wren, 1'b1);
        check("slot_addr", O_vid_addr, 14'h2040);
        check("slot_data", O_vid_data, 8'hA5);
        tick();
        @(negedge I_clock);
        check("slot_busy_clr", O_busy, 1'b0);
        check("slot_v", dut.v_q, 15'h2041);

        // Palette read bypass
        I_ppumask = 8'h00;
        reg_wr(6, 8'h3F);
        reg_wr(6, 8'h05);
        I_pal_data = 8'h2C;
        I_vid_data = 8'h77;
        @(negedge I_clock);
        check("pal_bypass", O_data, 8'h2C);
        cpu_access("pal", 1'b0, 8'h00, rd, nbusy, nwren, wa, wd);
        check("pal_rdata", rd, 8'h2C);
        check("pal_bus_addr", O_vid_addr, 14'h2F05);
        check("pal_v", dut.v_q, 15'h3F06);
        reg_wr(6, 8'h20);
        reg_wr(6, 8'h00);
        @(negedge I_clock);
        check("pal_buf_fill", O_data, 8'h77);

        // Render loopy updates
        I_ppumask = 8'h18;
        reg_rd(2);
        reg_wr(5, 8'hFD);
        @(negedge I_clock);
        check("fine_x", O_vid_fine, 3'd5);
        reg_wr(5, 8'hEF);
        reg_wr(0, 8'h00);
        strobe(3);
        check("copy_v", dut.v_q, 15'h73A0);
        strobe(2);
        check("copy_h", dut.v_q, 15'h73BF);
        strobe(1);
        check("incr_v_y29", dut.v_q, 15'h081F);
        strobe(0);
        check("incr_h_x31", dut.v_q, 15'h0C00);
        reg_rd(2);
        reg_wr(5, 8'h00);
        reg_wr(5, 8'hFF);
        strobe(3);
        check("copy_v_y31", dut.v_q, 15'h77E0);
        strobe(1);
        check("incr_v_y31", dut.v_q, 15'h0400);
        strobe(1);
        strobe(0);
        check("incr_plain", dut.v_q, 15'h1401);

        // Fetch addresses and mirroring
        strobe(4);
        @(negedge I_clock);
        check("nt_addr", O_vid_addr, 14'h2401);
        I_mirror = 3'd1; #1 check("mir_vert", O_ciram_a10, 1'b1);
        I_mirror = 3'd0; #1 check("mir_horz", O_ciram_a10, 1'b0);
        I_mirror = 3'd2; #1 check("mir_sa", O_ciram_a10, 1'b0);
        I_mirror = 3'd3; #1 check("mir_sb", O_ciram_a10, 1'b1);
        I_mirror = 3'd4; #1 check("mir_four", O_ciram_a10, 1'b1);
        I_mirror = 3'd7; #1 check("mir_7", O_ciram_a10, 1'b0);
        strobe(5);
        @(negedge I_clock);
        check("at_addr", O_vid_addr, 14'h27C0);
        I_vid_data = 8'hAB;
        strobe(8);
        I_ppuctrl = 8'h10;
        strobe(6);
        @(negedge I_clock);
        check("lo_addr", O_vid_addr, 14'h1AB1);
        strobe(7);
        @(negedge I_clock);
        check("hi_addr", O_vid_addr, 14'h1AB9);

        // Reset while waiting for a slot abandons the access
        I_ppuctrl = 8'h00;
        I_wren[7] = 1'b1;
        I_data    = 8'h3C;
        tick();
        I_wren = 8'h00;
        tick();
        @(negedge I_clock);
        check("wait_busy", O_busy, 1'b1);
        I_reset = 1'b0;
        #1;
        check("rst_mid_v", dut.v_q, 15'h0);
        check("rst_mid_busy", O_busy, 1'b0);
        tick();
        I_reset = 1'b1;
        I_idle_slot = 1'b1;
        nwren = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge I_clock);
            if (O_vid_wren) nwren++;
            tick();
        end
        I_idle_slot = 1'b0;
        check("rst_mid_no_write", nwren, 0);
        check("rst_mid_addr", O_vid_addr, 14'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
